motor_dc_top: RTL and testbench

MOTOR_DC_TOP -- requirements
Module: motor_dc_top

---
 rtl/motor_dc_top.sv | 166 ++++++++++++++++
 tb/tb_motor_dc_top.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/motor_dc_top.sv
// rtl/motor_dc_top.sv - DC motor PWM speed/direction controller with push-button speed step
//
// Purpose:
//   Derives 10 kHz and 1 kHz enable ticks from clk. Each accepted push of
//   speed_inc raises an 8-bit speed by SPEED_STEP, saturating at 255. An
//   8-bit PWM counter advanced on the 10 kHz tick drives ena = (counter < speed).
//   in1/in2 follow the synchronized forward input, and both are held low
//   (coast) while speed is zero.
//
// Build option:
//   MOTOR_DC_DEBOUNCE_EN - when defined, presses come from a 1 kHz-sampled
//   debouncer. When undefined, every rising edge of the synchronized raw
//   button counts as a press.
//
// Ports:
//   clk        in   system clock (CLK_FREQ Hz)
//   rst        in   asynchronous active-low reset
//   speed_inc  in   raw push-button, high = pressed (asynchronous)
//   forward    in   direction select, 1 = forward (asynchronous)
//   ena        out  PWM enable to H-bridge
//   in1, in2   out  H-bridge direction inputs
module motor_dc_top #(
    parameter int CLK_FREQ         = 12000000,
    parameter int SPEED_STEP       = 51,
    parameter int DEBOUNCE_SAMPLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic speed_inc,
    input  logic forward,
    output logic ena,
    output logic in1,
    output logic in2
);

    localparam int DIV_10K = CLK_FREQ / 10000;
    localparam int DIV_1K  = CLK_FREQ / 1000;
    localparam int W_10K   = $clog2(DIV_10K + 1);
    localparam int W_1K    = $clog2(DIV_1K + 1);

    logic [7:0]       speed;
    logic             clk_10kHz;
    logic             clk_1kHz;
    logic [W_10K-1:0] div_10k;
    logic [W_1K-1:0]  div_1k;
    logic [1:0]       inc_sync;
    logic [1:0]       fwd_sync;
    logic             press;
    logic [7:0]       pwm_cnt;
    logic [8:0]       speed_sum;

    // Tick dividers: the tick flop is set on the cycle the count wraps, so the
    // first tick after reset is seen exactly DIV cycles later.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_10k   <= '0;
            clk_10kHz <= 1'b0;
        end else if (div_10k == W_10K'(DIV_10K - 1)) begin
            div_10k   <= '0;
            clk_10kHz <= 1'b1;
        end else begin
            div_10k   <= div_10k + 1'b1;
            clk_10kHz <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_1k   <= '0;
            clk_1kHz <= 1'b0;
        end else if (div_1k == W_1K'(DIV_1K - 1)) begin
            div_1k   <= '0;
            clk_1kHz <= 1'b1;
        end else begin
            div_1k   <= div_1k + 1'b1;
            clk_1kHz <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inc_sync <= 2'b00;
            fwd_sync <= 2'b00;
        end else begin
            inc_sync <= {inc_sync[0], speed_inc};
            fwd_sync <= {fwd_sync[0], forward};
        end
    end

`ifdef MOTOR_DC_DEBOUNCE_EN
    localparam int DB_W = $clog2(DEBOUNCE_SAMPLES + 1);

    logic            db_level;
    logic [DB_W-1:0] db_cnt;

    // db_cnt counts consecutive samples that differ from the accepted level;
    // any sample matching the accepted level restarts the run. The press pulse
    // fires only on an accepted 0->1 change.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            db_level <= 1'b0;
            db_cnt   <= '0;
            press    <= 1'b0;
        end else begin
            press <= 1'b0;
            if (clk_1kHz) begin
                if (inc_sync[1] == db_level) begin
                    db_cnt <= '0;
                end else if (db_cnt == DB_W'(DEBOUNCE_SAMPLES - 1)) begin
                    db_level <= inc_sync[1];
                    db_cnt   <= '0;
                    press    <= inc_sync[1];
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end
        end
    end
`else
    logic inc_prev;
    logic unused_ok;

    // The 1 kHz tick and the debounce depth are not needed without the debouncer.
    assign unused_ok = &{1'b0, clk_1kHz, 1'(DEBOUNCE_SAMPLES)};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inc_prev <= 1'b0;
            press    <= 1'b0;
        end else begin
            inc_prev <= inc_sync[1];
            press    <= inc_sync[1] & ~inc_prev;
        end
    end
`endif

    // The sum is 9 bits wide so a carry out means saturation, never wrap.
    assign speed_sum = {1'b0, speed} + 9'(SPEED_STEP);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            speed <= 8'd0;
        end else if (press) begin
            speed <= speed_sum[8] ? 8'hFF : speed_sum[7:0];
        end
    end

    // ena is re-evaluated every clk, so a new speed applies within the
    // current PWM step rather than at the frame boundary.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pwm_cnt <= 8'd0;
            ena     <= 1'b0;
            in1     <= 1'b0;
            in2     <= 1'b0;
        end else begin
            if (clk_10kHz) begin
                pwm_cnt <= pwm_cnt + 8'd1;
            end
            ena <= (pwm_cnt < speed);
            in1 <= (speed != 8'd0) &  fwd_sync[1];
            in2 <= (speed != 8'd0) & ~fwd_sync[1];
        end
    end

endmodule

// File: tb/tb_motor_dc_top.sv
// tb/tb_motor_dc_top.sv - directed self-checking bench for motor_dc_top
module tb_motor_dc_top;

    logic clk       = 1'b0;
    logic rst       = 1'b0;
    logic speed_inc = 1'b0;
    logic forward   = 1'b1;
    logic ena;
    logic in1;
    logic in2;

    int errors    = 0;
    int checks    = 0;
    int exp_speed = 0;
    int highs     = 0;
    int first_10k = 0;
    int first_1k  = 0;

    // 40 kHz clock: 10 kHz tick every 4 cycles, 1 kHz tick every 40 cycles,
    // PWM frame of 1024 cycles.
    motor_dc_top #(
        .CLK_FREQ        (40000),
        .SPEED_STEP      (51),
        .DEBOUNCE_SAMPLES(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .speed_inc(speed_inc),
        .forward  (forward),
        .ena      (ena),
        .in1      (in1),
        .in2      (in2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic next_speed();
        exp_speed = (exp_speed + 51 > 255) ? 255 : exp_speed + 51;
    endtask

    task automatic clean_press();
        speed_inc = 1'b1;
        cycles(240);
        speed_inc = 1'b0;
        cycles(240);
    endtask

    task automatic bouncy_press();
        int w [6] = '{4, 6, 8, 10, 5, 7};
        foreach (w[i]) begin
            speed_inc = 1'b1;
            cycles(w[i]);
            speed_inc = 1'b0;
            cycles(2);
        end
        speed_inc = 1'b1; cycles(240);
        speed_inc = 1'b0; cycles(2);
        speed_inc = 1'b1; cycles(3);
        speed_inc = 1'b0; cycles(2);
        speed_inc = 1'b1; cycles(4);
        speed_inc = 1'b0; cycles(300);
    endtask

    task automatic measure(output int h);
        h = 0;
        repeat (1024) begin
            @(negedge clk);
            if (ena === 1'b1) h++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        cycles(5);
        rst = 1'b1;
        cycles(10);
        exp_speed = 0;
    endtask

    initial begin
        cycles(600);
        check("reset_ena", ena, 0);
        check("reset_in1", in1, 0);
        check("reset_in2", in2, 0);
        check("reset_speed", dut.speed, 0);

        rst = 1'b1;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (first_10k == 0 && dut.clk_10kHz === 1'b1) first_10k = c;
            if (first_1k == 0 && dut.clk_1kHz === 1'b1) first_1k = c;
        end
        check("first_10k_tick", first_10k, 4);
        check("first_1k_tick", first_1k, 40);

        measure(highs);
        check("duty_speed0", highs, 0);
        check("coast_in1", in1, 0);
        check("coast_in2", in2, 0);

        clean_press();
        next_speed();
        check("speed_press1", dut.speed, exp_speed);
        measure(highs);
        check("duty_speed51", highs, 51 * 4);
        check("fwd_in1", in1, 1);
        check("fwd_in2", in2, 0);

        for (int p = 2; p <= 6; p++) begin
            clean_press();
            next_speed();
            check($sformatf("speed_press%0d", p), dut.speed, exp_speed);
        end
        check("speed_sat", dut.speed, 255);
        measure(highs);
        check("duty_speed255", highs, 255 * 4);

        cycles(300);
        rst = 1'b0;
        #1;
        check("midframe_rst_ena", ena, 0);
        check("midframe_rst_in1", in1, 0);
        check("midframe_rst_in2", in2, 0);
        cycles(5);
        rst = 1'b1;
        cycles(10);
        exp_speed = 0;
        check("speed_after_rst", dut.speed, 0);

        clean_press();
        next_speed();
        clean_press();
        next_speed();
        check("speed_102", dut.speed, exp_speed);
        forward = 1'b0;
        cycles(3);
        check("rev_in1", in1, 0);
        check("rev_in2", in2, 1);
        measure(highs);
        check("duty_rev_102", highs, 102 * 4);
        check("rev_hold_in2", in2, 1);

        forward = 1'b1;
        do_reset();
        bouncy_press();
`ifdef MOTOR_DC_DEBOUNCE_EN
        check("bouncy_debounced", dut.speed, 51);
`else
        check("bouncy_raw_sat", dut.speed, 255);
`endif

        do_reset();
        speed_inc = 1'b1;
        cycles(100);
        rst = 1'b0;
        speed_inc = 1'b0;
        cycles(5);
        rst = 1'b1;
        cycles(300);
        check("middebounce_rst_speed", dut.speed, 0);
        check("middebounce_rst_ena", ena, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
